aes_cipher_iter: RTL
====================

// Module: aes_cipher_iter
// PURPOSE
//  Iterative AES encryption engine. Successor to the single-round combinational cipher stage.
//  Holds one 128-bit state register and reuses one round datapath NR times per block.
//  Supports AES-128/192/256 via parameter. Valid/ready on input and output; round keys come
//  from an external expanded-key store addressed by this block.
//  Sits between the block-I/O framing logic and the key-schedule RAM.
// PARAMETERS
//  NK        4   key length in 32-bit words: 4, 6 or 8; NR = NK+6 (10/12/14 rounds)
//  RKI_W     4   width of round-key index; must hold NR (4 covers 0..14)
// PORTS
//  clk        in   1        single clock, all state updates on rising edge
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        plaintext block offered
//  in_ready   out  1        block accepted when in_valid && in_ready
//  in_block   in   [0:127]  plaintext; byte 0 = bits [0:7], column-major as FIPS-197
//  rk_idx     out  RKI_W    index of round key required this cycle (0..NR)
//  rk_data    in   [0:127]  round key rk_idx; combinational, valid same cycle
//  out_valid  out  1        ciphertext available
//  out_ready  in   1        consumer takes ciphertext when out_valid && out_ready
//  out_block  out  [0:127]  ciphertext, stable while out_valid && !out_ready
//  busy       out  1        high in ROUND or DONE
// BEHAVIOUR
//  Reset: state IDLE, round counter 0, state reg 0, in_ready=1 after reset deasserts,
//   out_valid=0, out_block=0, rk_idx=0, busy=0.
//  FSM IDLE -> ROUND -> DONE -> IDLE.
//   IDLE : in_ready=1, rk_idx=0. On accept: st <= in_block ^ rk_data (initial AddRoundKey),
//          rnd <= 1, go ROUND.
//   ROUND: in_ready=0, rk_idx=rnd. st <= round(st, rk_data, final=(rnd==NR)).
//          rnd<NR: rnd++. rnd==NR: go DONE.
//   DONE : out_valid=1, out_block=st, in_ready=0, rk_idx=0.
//          On out_ready: go IDLE. If out_ready is low, hold indefinitely.
//  Round function: SubBytes -> ShiftRows -> MixColumns -> AddRoundKey.
//   Final round (rnd==NR) bypasses MixColumns.
//  Latency: accept at cycle T -> out_valid first high at T+NR+1.
//   Throughput: one block per NR+2 cycles when out_ready is held high.
//  No input accept in DONE, even when out_ready is high that cycle. Next accept is the
//   following cycle at the earliest.
//  in_valid while busy is ignored. The offered block is not captured until IDLE.
//  out_block is driven only from the state reg. No combinational path from in_block.
//  rk_idx is a pure function of FSM state and rnd, so key RAM may register its address.
//  rst mid-block: abort immediately, return to IDLE, discard the partial state.
//   No out_valid is produced for the aborted block.
//  Illegal NK (not 4/6/8): elaboration-time error.
// STRUCTURE
//  Package aes_pkg: NK_AES128/192/256 constants, function nr_of(nk), FSM state enum
//   {S_IDLE,S_ROUND,S_DONE}, 128-bit block typedef.
//  Sub-module aes_round: combinational one-round datapath (in, rk, final) -> out.
//   Composed of the existing SubBytes, ShiftRows, MixColumns and AddRoundKey stages,
//   plus a final-round mux around MixColumns.
//  Top: FSM, round counter, state reg, output handshake.
// TESTING (bench models the key store as a ROM of FIPS-197 expanded keys, indexed by rk_idx)
//  NK=4, key 2b7e1516..09cf4f3c, pt 3243f6a8885a308d313198a2e0370734
//   -> ct 3925841d02dc09fbdc118597196a0b32; out_valid at accept+11.
//  NK=4/6/8, key 000102..(16/24/32 bytes), pt 00112233445566778899aabbccddeeff
//   -> 69c4e0d86a7b0430d8cdb78070b4c55a / dda97ca4864cdfe06eaf70a0ec0d7191 /
//      8ea2b7ca516745bfeafc49904b496089.
//  Backpressure: hold out_ready=0 for 5 cycles in DONE.
//   -> out_valid and out_block stable; in_ready=0; the second in_valid is not accepted.
//  Back-to-back: in_valid held high, out_ready=1, 4 blocks.
//   -> accepts exactly every NR+2 cycles; all ciphertexts correct and in order.
//  Reset at round 5.
//   -> next cycle IDLE, out_valid=0, in_ready=1.
//   -> fresh block after reset gives the correct ciphertext.
//  rk_idx trace for one NK=4 block: 0 on the accept cycle, then 1..10 on consecutive cycles,
//   then 0 in DONE.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types, constants and byte-level helpers.
// Used by the iterative cipher and its round datapath.
package aes_pkg;

    localparam int NK_AES128 = 4;
    localparam int NK_AES192 = 6;
    localparam int NK_AES256 = 8;

    typedef logic [0:127] block_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_DONE
    } state_t;

    function automatic int nr_of(input int nk);
        return nk + 6;
    endfunction

    // Forward S-box, entry 0x00 first.
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns, AddRoundKey.
// The last round skips MixColumns.
module aes_round
    import aes_pkg::*;
(
    input  block_t in_state,
    input  block_t rk,
    input  logic   is_final,
    output block_t out_state
);

    function automatic block_t sub_bytes(input block_t s);
        block_t o;
        for (int i = 0; i < 16; i++) begin
            o[8*i +: 8] = sbox(s[8*i +: 8]);
        end
        return o;
    endfunction

    // Row r of column c takes the byte from column (c + r) mod 4.
    function automatic block_t shift_rows(input block_t s);
        block_t o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(r + 4*c) +: 8] = s[8*(r + 4*((c + r) % 4)) +: 8];
            end
        end
        return o;
    endfunction

    function automatic block_t mix_columns(input block_t s);
        block_t     o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c      +: 8];
            a1 = s[32*c + 8  +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            o[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    block_t sr;
    block_t mc;

    always_comb begin
        sr        = shift_rows(sub_bytes(in_state));
        mc        = mix_columns(sr);
        out_state = (is_final ? sr : mc) ^ rk;
    end

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryptor: one state register, one round datapath reused NR times.
// Round keys are fetched from an external store addressed by rk_idx.
module aes_cipher_iter
    import aes_pkg::*;
#(
    parameter int NK    = 4,
    parameter int RKI_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:127]     in_block,
    output logic [RKI_W-1:0] rk_idx,
    input  logic [0:127]     rk_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:127]     out_block,
    output logic             busy
);

    localparam int NR = nr_of(NK);
    localparam logic [RKI_W-1:0] RND_LAST = RKI_W'(NR);

    generate
        if (!(NK == NK_AES128 || NK == NK_AES192 || NK == NK_AES256)) begin : g_bad_nk
            $error("aes_cipher_iter: NK must be 4, 6 or 8");
        end
        if (NR >= (1 << RKI_W)) begin : g_bad_rki
            $error("aes_cipher_iter: RKI_W too narrow for NR");
        end
    endgenerate

    state_t           state, state_n;
    logic [RKI_W-1:0] rnd, rnd_n;
    block_t           st, st_n;
    block_t           round_out;

    aes_round u_round (
        .in_state (st),
        .rk       (rk_data),
        .is_final (rnd == RND_LAST),
        .out_state(round_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            rnd   <= '0;
            st    <= '0;
        end else begin
            state <= state_n;
            rnd   <= rnd_n;
            st    <= st_n;
        end
    end

    always_comb begin
        state_n = state;
        rnd_n   = rnd;
        st_n    = st;
        unique case (state)
            S_IDLE: begin
                if (in_valid) begin
                    st_n    = in_block ^ rk_data;
                    rnd_n   = RKI_W'(1);
                    state_n = S_ROUND;
                end
            end
            S_ROUND: begin
                st_n = round_out;
                if (rnd == RND_LAST) begin
                    rnd_n   = '0;
                    state_n = S_DONE;
                end else begin
                    rnd_n = rnd + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs depend only on registered state, never on the input block.
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign rk_idx    = (state == S_ROUND) ? rnd : '0;
    assign out_block = st;

endmodule
